mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl, the fetch/memory stages and the byte RAM.
// slave: controller side; master: requester/RAM side.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_pc;
  logic [31:0] inst_o;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_wr, mem_addr,
    input  mem_len, mem_wdata, ram_din,
    output if_done, if_pc, inst_o,
    output mem_done, mem_rdata,
    output ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_wr, mem_addr,
    output mem_len, mem_wdata, ram_din,
    input  if_done, if_pc, inst_o,
    input  mem_done, mem_rdata,
    input  ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Fetch/memory-stage arbiter serialising accesses onto a byte-wide RAM.
// Ports: clk, rst (sync, active-high), bus (mem_ctrl_if.slave).
module mem_ctrl (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, IF_RD, MEM_RD, MEM_WR, DONE
  } state_t;

  state_t      st;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [2:0]  len;
  logic [2:0]  cnt;

  logic [2:0]  cnt1;
  logic [31:0] nxt_a;
  logic [1:0]  ridx;
  logic [1:0]  widx;
  logic [31:0] cap;
  logic [2:0]  mlen;

  assign cnt1  = cnt + 3'd1;
  assign nxt_a = base + {29'd0, cnt1};
  // Byte arriving now belongs to the address shown last cycle.
  assign ridx  = 2'(cnt - 3'd1);
  assign widx  = 2'(cnt1);

  always_comb begin
    cap = rbuf;
    cap[{ridx, 3'b000} +: 8] = bus.ram_din;
  end

  always_comb begin
    mlen = 3'd4;
    unique case (bus.mem_len)
      2'd0:    mlen = 3'd1;
      2'd1:    mlen = 3'd2;
      default: mlen = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      base          <= '0;
      wdata         <= '0;
      rbuf          <= '0;
      len           <= '0;
      cnt           <= '0;
      bus.if_done   <= 1'b0;
      bus.if_pc     <= '0;
      bus.inst_o    <= '0;
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= '0;
      bus.ram_a     <= '0;
      bus.ram_dout  <= '0;
      bus.ram_wr    <= 1'b0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      unique case (st)
        IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (bus.mem_req) begin
            base       <= bus.mem_addr;
            wdata      <= bus.mem_wdata;
            len        <= mlen;
            bus.ram_a  <= bus.mem_addr;
            bus.ram_wr <= bus.mem_wr;
            if (bus.mem_wr) begin
              bus.ram_dout <= bus.mem_wdata[7:0];
              st           <= MEM_WR;
            end else begin
              st           <= MEM_RD;
            end
          end else if (bus.if_req) begin
            base      <= bus.if_addr;
            len       <= 3'd4;
            bus.ram_a <= bus.if_addr;
            st        <= IF_RD;
          end
        end
        IF_RD, MEM_RD: begin
          cnt <= cnt1;
          if (cnt != 3'd0)
            rbuf <= cap;
          if (cnt1 < len)
            bus.ram_a <= nxt_a;
          else
            bus.ram_a <= '0;
          if (cnt == len) begin
            st <= DONE;
            if (st == IF_RD) begin
              bus.if_done <= 1'b1;
              bus.inst_o  <= cap;
              bus.if_pc   <= base;
            end else begin
              bus.mem_done  <= 1'b1;
              bus.mem_rdata <= cap;
            end
          end
        end
        MEM_WR: begin
          if (cnt1 < len) begin
            cnt          <= cnt1;
            bus.ram_a    <= nxt_a;
            bus.ram_dout <= wdata[{widx, 3'b000} +: 8];
          end else begin
            bus.ram_a    <= '0;
            bus.ram_dout <= '0;
            bus.ram_wr   <= 1'b0;
            bus.mem_done <= 1'b1;
            st           <= DONE;
          end
        end
        DONE: begin
          st <= IDLE;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small byte-RAM model.
// Checks cycle timing, data assembly, writes and reset behaviour.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sparse RAM folded onto 256 entries; test addresses do not collide.
  logic [7:0] ram [256];
  logic       pk_en;
  logic       clr;
  logic [31:0] pk_a;
  logic [7:0]  pk_d;

  function automatic logic [7:0] ix(input logic [31:0] a);
    return {a[15:12], a[3:0]};
  endfunction

  always @(posedge clk) begin
    bus.ram_din <= ram[ix(bus.ram_a)];
    if (clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (pk_en) begin
      ram[ix(pk_a)] <= pk_d;
    end else if (bus.ram_wr) begin
      ram[ix(bus.ram_a)] <= bus.ram_dout;
    end
  end

  int n_cmp;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pk_a  = a;
    pk_d  = d;
    pk_en = 1'b1;
    @(posedge clk);
    #1;
    pk_en = 1'b0;
  endtask

  logic        ifd [32];
  logic        md  [32];
  logic        wr  [32];
  logic [31:0] ra  [32];
  logic [7:0]  rd  [32];

  // Runs n cycles from cycle 0; requests drop after the given cycles.
  task automatic run(input int n, input int drop_if,
                     input int drop_mem, input int rst_at);
    for (int c = 0; c < 32; c++) begin
      ifd[c] = 1'b0; md[c] = 1'b0; wr[c] = 1'b0;
      ra[c] = '0; rd[c] = '0;
    end
    for (int c = 0; c < n; c++) begin
      rst = (c == rst_at);
      @(negedge clk);
      ifd[c] = bus.if_done;
      md[c]  = bus.mem_done;
      wr[c]  = bus.ram_wr;
      ra[c]  = bus.ram_a;
      rd[c]  = bus.ram_dout;
      @(posedge clk);
      #1;
      if (c == drop_if)  bus.if_req  = 1'b0;
      if (c == drop_mem) bus.mem_req = 1'b0;
    end
    rst = 1'b0;
  endtask

  function automatic int first(input logic v [32]);
    for (int c = 0; c < 32; c++)
      if (v[c]) return c;
    return -1;
  endfunction

  function automatic int ones(input logic v [32]);
    int k = 0;
    for (int c = 0; c < 32; c++)
      if (v[c]) k++;
    return k;
  endfunction

  task automatic set_mem(input logic wr_i, input logic [1:0] ln,
                         input logic [31:0] a, input logic [31:0] d);
    bus.mem_req   = 1'b1;
    bus.mem_wr    = wr_i;
    bus.mem_len   = ln;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    clr = 1'b1;
    pk_en = 1'b0;
    pk_a = '0;
    pk_d = '0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_wr = 1'b0;
    bus.mem_len = '0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_inst", bus.inst_o, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_ram", bus.ram_a | {23'd0, bus.ram_wr, bus.ram_dout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr = 1'b0;

    poke(32'h4, 8'h13); poke(32'h5, 8'h05);
    poke(32'h6, 8'h50); poke(32'h7, 8'h00);
    poke(32'h1000, 8'h78); poke(32'h1001, 8'h56);
    poke(32'h1002, 8'h34); poke(32'h1003, 8'h12);
    poke(32'h0, 8'h93);
    poke(32'h3001, 8'hFF); poke(32'h3002, 8'hAA);
    poke(32'h8, 8'h11); poke(32'h9, 8'h22);
    poke(32'hA, 8'h33); poke(32'hB, 8'h44);
    poke(32'hFFFFFFFE, 8'h01); poke(32'hFFFFFFFF, 8'h02);

    // Word fetch
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4;
    run(10, 0, -1, -1);
    chk("if_done_cyc", 32'(first(ifd)), 32'd6);
    chk("if_done_cnt", 32'(ones(ifd)), 32'd1);
    chk("if_no_wr", 32'(ones(wr)), 32'd0);
    chk("if_a1", ra[1], 32'h4);
    chk("if_a4", ra[4], 32'h7);
    chk("if_a5", ra[5], 32'h0);
    chk("if_inst", bus.inst_o, 32'h00500513);
    chk("if_pc", bus.if_pc, 32'h4);

    // Arbitration
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    set_mem(1'b0, 2'd2, 32'h1000, 32'h0);
    run(16, 7, 0, -1);
    chk("arb_mdone", 32'(first(md)), 32'd6);
    chk("arb_idone", 32'(first(ifd)), 32'd13);
    chk("arb_a8", ra[8], 32'h0);
    chk("arb_a11", ra[11], 32'h3);
    chk("arb_rdata", bus.mem_rdata, 32'h12345678);
    chk("arb_inst", bus.inst_o, 32'h00000093);
    chk("arb_pc", bus.if_pc, 32'h0);

    // Half store
    set_mem(1'b1, 2'd1, 32'h2002, 32'h0000BEEF);
    run(6, -1, 0, -1);
    chk("hs_wr1", {31'd0, wr[1]}, 32'd1);
    chk("hs_a1", ra[1], 32'h2002);
    chk("hs_d1", {24'd0, rd[1]}, 32'hEF);
    chk("hs_a2", ra[2], 32'h2003);
    chk("hs_d2", {24'd0, rd[2]}, 32'hBE);
    chk("hs_wrcnt", 32'(ones(wr)), 32'd2);
    chk("hs_mdone", 32'(first(md)), 32'd3);
    chk("hs_ram2", {24'd0, ram[ix(32'h2002)]}, 32'hEF);
    chk("hs_ram3", {24'd0, ram[ix(32'h2003)]}, 32'hBE);
    chk("hs_ram4", {24'd0, ram[ix(32'h2004)]}, 32'h00);
    chk("hs_hold", bus.mem_rdata, 32'h12345678);

    // Byte load
    set_mem(1'b0, 2'd0, 32'h3001, 32'h0);
    run(6, -1, 0, -1);
    chk("bl_mdone", 32'(first(md)), 32'd3);
    chk("bl_rdata", bus.mem_rdata, 32'h000000FF);

    // Dropped fetch
    bus.if_req = 1'b1;
    bus.if_addr = 32'h8;
    run(9, 1, -1, -1);
    chk("df_idone", 32'(first(ifd)), 32'd6);
    chk("df_pc", bus.if_pc, 32'h8);
    chk("df_inst", bus.inst_o, 32'h44332211);

    // Wrapping word load, len 3
    set_mem(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0);
    run(9, -1, 0, -1);
    chk("wr_a2", ra[2], 32'hFFFFFFFF);
    chk("wr_a3", ra[3], 32'h0);
    chk("wr_mdone", 32'(first(md)), 32'd6);
    chk("wr_rdata", bus.mem_rdata, 32'h00930201);

    // Reset together with a request
    set_mem(1'b1, 2'd2, 32'h4000, 32'hDEADBEEF);
    run(6, -1, 0, 0);
    chk("rr_wrcnt", 32'(ones(wr)), 32'd0);
    chk("rr_mdone", 32'(ones(md)), 32'd0);

    // Reset during a word store
    set_mem(1'b1, 2'd2, 32'h4000, 32'hA1B2C3D4);
    run(8, -1, 0, 2);
    chk("rs_wr12", {30'd0, wr[1], wr[2]}, 32'd3);
    chk("rs_wr3", {31'd0, wr[3]}, 32'd0);
    chk("rs_mdone", 32'(ones(md)), 32'd0);
    chk("rs_ram0", {24'd0, ram[ix(32'h4000)]}, 32'hD4);
    chk("rs_ram1", {24'd0, ram[ix(32'h4001)]}, 32'hC3);
    chk("rs_ram2", {24'd0, ram[ix(32'h4002)]}, 32'h00);
    set_mem(1'b0, 2'd0, 32'h4001, 32'h0);
    run(6, -1, 0, -1);
    chk("rs_next_done", 32'(first(md)), 32'd3);
    chk("rs_next_data", bus.mem_rdata, 32'h000000C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
